// File: rtl/lynxTypes.sv
// -----------------------------------------------------------------------------
// lynxTypes
// Shared types and defaults for the MMU weighted round-robin request merger.
//   N_REGIONS          : default number of request channels
//   DEF_N_OUTSTANDING  : default in-flight request limit per channel
//   PADDR_BITS/LEN_BITS: request field widths
//   mux_ord_t          : ordering record {ch_id, len} sent beside each merged request
//   arb_state_e        : arbiter FSM encoding
// -----------------------------------------------------------------------------
package lynxTypes;

    localparam int N_REGIONS         = 4;
    localparam int DEF_N_OUTSTANDING = 8;
    localparam int PADDR_BITS        = 32;
    localparam int LEN_BITS          = 16;
    // Wide enough for up to 16 channels.
    localparam int CH_ID_BITS        = 4;

    typedef struct packed {
        logic [CH_ID_BITS-1:0] ch_id;
        logic [LEN_BITS-1:0]   len;
    } mux_ord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mmu_wrr_credit.sv
// -----------------------------------------------------------------------------
// mmu_wrr_credit
// Per-channel in-flight request counter.
//   aclk, aresetn : clock, synchronous active-low reset
//   inc_i         : a request of this channel was issued this cycle
//   dec_i         : a request of this channel completed this cycle
//   cnt_o         : current in-flight count, 0..N_OUT (never wraps)
//   err_o         : sticky, set when a completion arrives with a zero count
// -----------------------------------------------------------------------------
module mmu_wrr_credit
    import lynxTypes::*;
#(
    parameter  int N_OUT = DEF_N_OUTSTANDING,
    localparam int CNT_W = $clog2(N_OUT) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_OUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count: simultaneous issue and completion cancel out; saturate at both ends.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                else                  cnt_d = cnt_q;
            end
            2'b01: begin
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - CNT_ONE;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter and sticky error registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/mmu_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_wrr_arbiter
// Weighted round-robin merger of N_CH request channels into one request stream
// plus an ordering record, with per-channel outstanding-request credits.
//   aclk, aresetn        : clock, synchronous active-low reset
//   s_req_*[N_CH]        : per-channel requests (valid/ready, paddr, len, last)
//   m_req_*              : merged request (valid/ready, paddr, len, last)
//   m_mux_*              : ordering record {ch_id, len} (valid/ready, data)
//   weight[N_CH]         : burst length per grant (0 treated as 1), read at grant start
//   xfer_done[N_CH]      : completion pulse, returns one credit
//   credit_err[N_CH]     : sticky completion-without-credit flag
// -----------------------------------------------------------------------------
module mmu_wrr_arbiter
    import lynxTypes::*;
#(
    parameter  int N_CH          = N_REGIONS,
    parameter  int WGT_BITS      = 4,
    parameter  int N_OUTSTANDING = DEF_N_OUTSTANDING,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CNT_W         = $clog2(N_OUTSTANDING) + 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [N_CH-1:0]                 s_req_valid,
    output logic [N_CH-1:0]                 s_req_ready,
    input  logic [N_CH-1:0][PADDR_BITS-1:0] s_req_paddr,
    input  logic [N_CH-1:0][LEN_BITS-1:0]   s_req_len,
    input  logic [N_CH-1:0]                 s_req_last,
    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic [PADDR_BITS-1:0]           m_req_paddr,
    output logic [LEN_BITS-1:0]             m_req_len,
    output logic                            m_req_last,
    output logic                            m_mux_valid,
    input  logic                            m_mux_ready,
    output mux_ord_t                        m_mux_data,
    input  logic [N_CH-1:0][WGT_BITS-1:0]   weight,
    input  logic [N_CH-1:0]                 xfer_done,
    output logic [N_CH-1:0]                 credit_err
);

    localparam int                  SW      = CH_W + 1;
    localparam logic [CH_W-1:0]     CH_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]     CH_LAST = CH_W'(N_CH - 1);
    localparam logic [N_CH-1:0]     BIT0    = N_CH'(1);
    localparam logic [WGT_BITS-1:0] W_ONE   = WGT_BITS'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(N_OUTSTANDING);

    arb_state_e                 state_q, state_d;
    logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d, gnt_ch_q, gnt_ch_d;
    logic [WGT_BITS-1:0]        burst_cnt_q, burst_cnt_d, grant_burst_s;
    logic                       req_vld_q, req_vld_d, mux_vld_q, mux_vld_d;
    logic [PADDR_BITS-1:0]      paddr_q, paddr_d;
    logic [LEN_BITS-1:0]        len_q, len_d;
    logic                       last_q, last_d;
    logic [CH_W-1:0]            och_q, och_d;

    logic [N_CH-1:0][CNT_W-1:0] cnt_s;
    logic [N_CH-1:0]            full_s, elig_s, gnt_mask_s;
    logic [CH_W-1:0]            pick_s, search_base_s, next_ptr_s;
    logic                       pick_found_s, out_free_s, issue_s, other_elig_s;

    // Per-channel credit counters.
    for (genvar i = 0; i < N_CH; i++) begin : g_credit
        mmu_wrr_credit #(.N_OUT(N_OUTSTANDING)) u_credit (
            .aclk    (aclk),
            .aresetn (aresetn),
            .inc_i   (s_req_ready[i]),
            .dec_i   (xfer_done[i]),
            .cnt_o   (cnt_s[i]),
            .err_o   (credit_err[i])
        );
        assign full_s[i] = (cnt_s[i] == CNT_MAX);
    end

    assign elig_s       = s_req_valid & ~full_s;
    assign gnt_mask_s   = BIT0 << gnt_ch_q;
    assign other_elig_s = |(elig_s & ~gnt_mask_s);
    assign next_ptr_s   = (gnt_ch_q == CH_LAST) ? '0 : gnt_ch_q + CH_ONE;
    // DRAIN re-grants from the already-advanced pointer in the same cycle.
    assign search_base_s = (state_q == ST_DRAIN) ? next_ptr_s : rr_ptr_q;
    // The slot accepts a new entry when each half is empty or handshaking now.
    assign out_free_s   = (!req_vld_q || m_req_ready) && (!mux_vld_q || m_mux_ready);
    assign issue_s      = aresetn && (state_q == ST_GRANT) && elig_s[gnt_ch_q] && out_free_s;
    assign s_req_ready  = issue_s ? gnt_mask_s : '0;

    // Round-robin search for the first eligible channel at or after the base.
    always_comb begin : rr_search
        logic [SW-1:0]   sum_v;
        logic [CH_W-1:0] idx_v;
        pick_s       = '0;
        pick_found_s = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            sum_v = {1'b0, search_base_s} + SW'(k);
            if (sum_v >= SW'(N_CH)) sum_v = sum_v - SW'(N_CH);
            else                    sum_v = sum_v;
            idx_v = sum_v[CH_W-1:0];
            if (!pick_found_s && elig_s[idx_v]) begin
                pick_s       = idx_v;
                pick_found_s = 1'b1;
            end else begin
                pick_s       = pick_s;
                pick_found_s = pick_found_s;
            end
        end
    end

    // Burst length of a new grant; a zero weight still allows one request.
    always_comb begin
        if (weight[pick_s] == '0) grant_burst_s = W_ONE;
        else                      grant_burst_s = weight[pick_s];
    end

    // Arbiter FSM next state.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_ch_d    = gnt_ch_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d     = ST_GRANT;
                    gnt_ch_d    = pick_s;
                    burst_cnt_d = grant_burst_s;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (issue_s) begin
                    burst_cnt_d = burst_cnt_q - W_ONE;
                    if ((burst_cnt_q == W_ONE) || (s_req_last[gnt_ch_q] && other_elig_s))
                        state_d = ST_DRAIN;
                    else
                        state_d = ST_GRANT;
                end else if (!elig_s[gnt_ch_q]) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                rr_ptr_d = next_ptr_s;
                if (pick_found_s) begin
                    state_d     = ST_GRANT;
                    gnt_ch_d    = pick_s;
                    burst_cnt_d = grant_burst_s;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot: each valid drops on its own handshake; an issue reloads both.
    always_comb begin
        req_vld_d = req_vld_q && !m_req_ready;
        mux_vld_d = mux_vld_q && !m_mux_ready;
        paddr_d   = paddr_q;
        len_d     = len_q;
        last_d    = last_q;
        och_d     = och_q;
        if (issue_s) begin
            req_vld_d = 1'b1;
            mux_vld_d = 1'b1;
            paddr_d   = s_req_paddr[gnt_ch_q];
            len_d     = s_req_len[gnt_ch_q];
            last_d    = s_req_last[gnt_ch_q];
            och_d     = gnt_ch_q;
        end else begin
            och_d     = och_q;
        end
    end

    // FSM, pointer and output-slot registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_ch_q    <= '0;
            burst_cnt_q <= '0;
            req_vld_q   <= 1'b0;
            mux_vld_q   <= 1'b0;
            paddr_q     <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
            och_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_ch_q    <= gnt_ch_d;
            burst_cnt_q <= burst_cnt_d;
            req_vld_q   <= req_vld_d;
            mux_vld_q   <= mux_vld_d;
            paddr_q     <= paddr_d;
            len_q       <= len_d;
            last_q      <= last_d;
            och_q       <= och_d;
        end
    end

    assign m_req_valid = req_vld_q;
    assign m_req_paddr = paddr_q;
    assign m_req_len   = len_q;
    assign m_req_last  = last_q;
    assign m_mux_valid = mux_vld_q;
    assign m_mux_data  = {CH_ID_BITS'(och_q), len_q};

endmodule
